// File: rtl/bnn_pkg.sv
// bnn_pkg: FSM state encoding and elaboration helpers shared by the BNN layers.
// Rev 1.0
`default_nettype none

package bnn_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Elaboration-time ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bnn_linebuf.sv
// bnn_linebuf: 1-bit simple dual-port register array, synchronous write, asynchronous read.
// Rev 1.0
`default_nettype none

module bnn_linebuf
  import bnn_pkg::*;
#(
  parameter int DEPTH = 15,
  parameter int AW    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);

  logic [DEPTH-1:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/bnn_maxpool2x2.sv
// bnn_maxpool2x2: 2x2 stride-2 max pool (OR) over a raster 1-bit feature-map stream.
// Rev 1.0
`default_nettype none

module bnn_maxpool2x2
  import bnn_pkg::*;
#(
  parameter int IN_ROWS    = 30,
  parameter int IN_COLS    = 30,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  in_bit,
  output logic                  out_valid,
  output logic                  out_bit,
  output logic [ADDR_WIDTH-1:0] out_address,
  output logic                  busy,
  output logic                  done
);

  localparam int BUF_DEPTH = (IN_COLS / 2 < 1) ? 1 : IN_COLS / 2;
  localparam int BUF_AW    = (clog2(BUF_DEPTH) < 1) ? 1 : clog2(BUF_DEPTH);
  localparam int COL_W     = (clog2(IN_COLS) < 1) ? 1 : clog2(IN_COLS);
  localparam int ROW_W     = (clog2(IN_ROWS) < 1) ? 1 : clog2(IN_ROWS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_ROWS - 1);

  logic [1:0]            state_q,     state_d;
  logic [COL_W-1:0]      col_q,       col_d;
  logic [ROW_W-1:0]      row_q,       row_d;
  logic                  pair_q,      pair_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_bit_q,   out_bit_d;
  logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
  logic                  done_q,      done_d;

  logic              w_accept;
  logic              w_start;
  logic              w_buf_we;
  logic [BUF_AW-1:0] w_buf_idx;
  logic              w_buf_rdata;

  assign w_accept  = (state_q == ST_RUN) && in_valid;
  assign w_start   = start && (state_q != ST_RUN);
  assign w_buf_idx = BUF_AW'(col_q >> 1);

  bnn_linebuf #(
    .DEPTH (BUF_DEPTH),
    .AW    (BUF_AW)
  ) u_linebuf (
    .clk_i   (clk),
    .we_i    (w_buf_we),
    .waddr_i (w_buf_idx),
    .wdata_i (pair_q | in_bit),
    .raddr_i (w_buf_idx),
    .rdata_o (w_buf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    paddr_d     = paddr_q;
    out_valid_d = 1'b0;
    out_bit_d   = out_bit_q;
    out_addr_d  = out_addr_q;
    done_d      = done_q;
    w_buf_we    = 1'b0;

    if (w_start) begin
      state_d = ST_RUN;
      col_d   = '0;
      row_d   = '0;
      pair_d  = 1'b0;
      paddr_d = '0;
      done_d  = 1'b0;
    end else if (w_accept) begin
      // Trailing odd column/row never reach the odd/odd branch, giving floor semantics.
      if (!col_q[0]) begin
        pair_d = in_bit;
      end else if (!row_q[0]) begin
        w_buf_we = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_bit_d   = w_buf_rdata | pair_q | in_bit;
        out_addr_d  = paddr_q;
        paddr_d     = paddr_q + ADDR_WIDTH'(1);
      end

      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
        if (row_q == LAST_ROW) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= 1'b0;
      paddr_q     <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      paddr_q     <= paddr_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_bit     = out_bit_q;
  assign out_address = out_addr_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bnn_maxpool2x2.sv
// tb_bnn_maxpool2x2: directed self-checking bench for a 4x4 and a 5x5 pooling instance.
// Rev 1.0
`default_nettype none

module tb_bnn_maxpool2x2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start44, start55;
  logic        in_valid, in_bit;
  logic        ov44, ob44, busy44, done44;
  logic        ov55, ob55, busy55, done55;
  logic [15:0] oa44, oa55;

  int n_cmp = 0;
  int n_err = 0;
  logic img [0:4][0:4];

  always #5 clk = ~clk;

  bnn_maxpool2x2 #(.IN_ROWS(4), .IN_COLS(4), .ADDR_WIDTH(16)) u_dut44 (
    .clk(clk), .reset(reset), .start(start44), .in_valid(in_valid), .in_bit(in_bit),
    .out_valid(ov44), .out_bit(ob44), .out_address(oa44), .busy(busy44), .done(done44)
  );

  bnn_maxpool2x2 #(.IN_ROWS(5), .IN_COLS(5), .ADDR_WIDTH(16)) u_dut55 (
    .clk(clk), .reset(reset), .start(start55), .in_valid(in_valid), .in_bit(in_bit),
    .out_valid(ov55), .out_bit(ob55), .out_address(oa55), .busy(busy55), .done(done55)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_check(input int sel, input string tag, input logic ev, input logic eb,
                            input logic [15:0] ea, input logic ed, input logic ebusy);
    logic v, b, bz, d;
    logic [15:0] a;
    v  = (sel == 1) ? ov55   : ov44;
    b  = (sel == 1) ? ob55   : ob44;
    a  = (sel == 1) ? oa55   : oa44;
    bz = (sel == 1) ? busy55 : busy44;
    d  = (sel == 1) ? done55 : done44;
    chk({tag, ".valid"}, 32'(v), 32'(ev));
    if (ev) begin
      chk({tag, ".bit"}, 32'(b), 32'(eb));
      chk({tag, ".addr"}, 32'(a), 32'(ea));
    end
    chk({tag, ".done"}, 32'(d), 32'(ed));
    chk({tag, ".busy"}, 32'(bz), 32'(ebusy));
  endtask

  task automatic do_start(input int sel, input string tag);
    if (sel == 1) start55 = 1'b1; else start44 = 1'b1;
    @(posedge clk); #1;
    start44 = 1'b0;
    start55 = 1'b0;
    step_check(sel, {tag, ".start"}, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic run_frame(input int sel, input string tag, input int rows, input int cols,
                           input bit gaps, input int mid_start);
    logic [15:0] ea;
    logic ev, eb, last;
    ea = 16'd0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (gaps && $urandom_range(0, 1) == 1) begin
          in_valid = 1'b0;
          in_bit   = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          step_check(sel, $sformatf("%s.gap%0d_%0d", tag, r, c), 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        end
        in_valid = 1'b1;
        in_bit   = img[r][c];
        if (r * cols + c == mid_start) begin
          if (sel == 1) start55 = 1'b1; else start44 = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        start44  = 1'b0;
        start55  = 1'b0;
        ev = (r % 2 == 1) && (c % 2 == 1) && (r < (rows / 2) * 2) && (c < (cols / 2) * 2);
        eb = 1'b0;
        if (ev) eb = img[r-1][c-1] | img[r-1][c] | img[r][c-1] | img[r][c];
        last = (r == rows - 1) && (c == cols - 1);
        step_check(sel, $sformatf("%s.px%0d_%0d", tag, r, c), ev, eb, ea, last, !last);
        if (ev) ea++;
      end
    end
    @(posedge clk); #1;
    step_check(sel, {tag, ".post"}, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        case (mode)
          1:       img[r][c] = (r == 4) || (c == 4);
          2:       img[r][c] = 1'((r + c) % 2);
          3:       img[r][c] = 1'b1;
          default: img[r][c] = 1'b0;
        endcase
  endtask

  initial begin
    reset    = 1'b1;
    start44  = 1'b0;
    start55  = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step_check(0, "rst44", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    step_check(1, "rst55", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    chk("rst44.bit", 32'(ob44), 32'd0);
    chk("rst44.addr", 32'(oa44), 32'd0);
    reset = 1'b0;

    // All-zero 4x4 frame, continuous input.
    fill(0);
    do_start(0, "zero");
    run_frame(0, "zero", 4, 4, 1'b0, -1);

    // Single one at row 2 col 3; a start pulse mid-frame must be ignored.
    fill(0);
    img[2][3] = 1'b1;
    do_start(0, "single");
    run_frame(0, "single", 4, 4, 1'b0, 5);

    // 5x5: ones only in the trailing row and column, which are never pooled.
    fill(1);
    do_start(1, "odd");
    run_frame(1, "odd", 5, 5, 1'b0, -1);

    // Checkerboard with gapped in_valid.
    fill(2);
    do_start(0, "chk");
    run_frame(0, "chk", 4, 4, 1'b1, -1);

    // Abandon a frame with reset after 6 pixels, then an all-ones frame.
    fill(3);
    do_start(0, "abort");
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    step_check(0, "abort.rst", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    step_check(0, "abort.idle", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    do_start(0, "ones");
    run_frame(0, "ones", 4, 4, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
